// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and control-field encodings shared by the multicycle MIPS controller.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b001;
  localparam logic [2:0] ALU_OP_SUB   = 3'b010;
  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: pure combinational state -> datapath control word (Moore outputs).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  cw_o
);
  always_comb begin
    cw_o = '0;
    case (state_i)
      FETCH: begin
        cw_o.mem_read  = 1'b1;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
        cw_o.alu_src_b = ALU_SRC_B_FOUR;
        cw_o.alu_op    = ALU_OP_ADD;
        cw_o.pc_source = PC_SRC_ALU;
      end
      DECODE: begin
        cw_o.alu_src_b = ALU_SRC_B_IMM_SH;
        cw_o.alu_op    = ALU_OP_ADD;
      end
      MEMADR, ADDIEX: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = ALU_SRC_B_IMM;
        cw_o.alu_op    = ALU_OP_ADD;
      end
      MEMRD: begin
        cw_o.mem_read = 1'b1;
        cw_o.i_or_d   = 1'b1;
      end
      MEMWB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        cw_o.mem_write = 1'b1;
        cw_o.i_or_d    = 1'b1;
      end
      EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = ALU_SRC_B_REG;
        cw_o.alu_op    = ALU_OP_FUNCT;
      end
      ALUWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.reg_dst   = 1'b1;
      end
      ADDIWB: cw_o.reg_write = 1'b1;
      BRANCH: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_src_b     = ALU_SRC_B_REG;
        cw_o.alu_op        = ALU_OP_SUB;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PC_SRC_ALUOUT;
      end
      JUMP: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PC_SRC_JUMP;
      end
      default: cw_o = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
// MEM_WAIT_EN adds mem_ready; FETCH/MEMRD/MEMWR then stall until memory completes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op
);
  state_e     state_q, state_d;
  ctrl_t      cw, g;
  logic       rdy;
  logic [5:0] opc;
`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  assign opc = 6'(op);
  mips_ctrl_decode u_decode (.state_i(state_q), .cw_o(cw));
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  always_comb begin
    state_d    = FETCH;
    illegal_op = 1'b0;
    case (state_q)
      FETCH:  state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        state_d    = opc == OP_RTYPE                ? EXEC   :
                     (opc == OP_LW || opc == OP_SW) ? MEMADR :
                     opc == OP_BEQ                  ? BRANCH :
                     opc == OP_ADDI                 ? ADDIEX :
                     opc == OP_J                    ? JUMP   : FETCH;
        illegal_op = state_d == FETCH;
      end
      MEMADR: state_d = opc == OP_LW ? MEMRD : MEMWR;
      MEMRD:  state_d = rdy ? MEMWB : MEMRD;
      MEMWR:  state_d = rdy ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // State sits at FETCH during reset, so its outputs must be forced off explicitly.
  assign g             = reset ? '0 : cw;
  assign pc_write      = g.pc_write & (rdy | state_q != FETCH);
  assign ir_write      = g.ir_write & rdy;
  assign pc_write_cond = g.pc_write_cond;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign i_or_d        = g.i_or_d;
  assign mem_read      = g.mem_read;
  assign mem_write     = g.mem_write;
  assign mem_to_reg    = g.mem_to_reg;
  assign reg_dst       = g.reg_dst;
  assign reg_write     = g.reg_write;
  assign alu_src_a     = g.alu_src_a;
  assign alu_src_b     = g.alu_src_b;
  assign alu_op        = ALUOP_W'(g.alu_op);
  assign pc_source     = g.pc_source;
endmodule
